// File: rtl/text_console_writer_pkg.sv
// Shared types and constants for the text console writer: FSM state
// encoding, the control codepoints it interprets and the default geometry.
package text_console_writer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PUT,
        ST_CLR_LINE,
        ST_CLR_ALL
    } state_t;

    localparam logic [7:0] CH_CR  = 8'h0D;
    localparam logic [7:0] CH_LF  = 8'h0A;
    localparam logic [7:0] CH_BS  = 8'h08;
    localparam logic [7:0] CH_TAB = 8'h09;
    localparam logic [7:0] CH_FF  = 8'h0C;

    localparam int DEFAULT_COLS = 80;
    localparam int DEFAULT_ROWS = 30;

    // Row after a line advance; the screen does not scroll, it wraps to the top.
    function automatic logic [4:0] next_row(input logic [4:0] row, input int rows);
        return (int'(row) == rows - 1) ? 5'd0 : row + 5'd1;
    endfunction

endpackage

// File: rtl/text_console_writer_if.sv
// Word-wide write bus shared with the text-mode GPU screenbuffer.
// The console is the master; the screenbuffer answers with ready.
interface text_console_writer_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic        wen;
    logic        ren;
    logic        ready;

    modport master (output addr, output wdata, output wmask, output wen, output ren, input ready);
    modport slave  (input addr, input wdata, input wmask, input wen, input ren, output ready);
endinterface

// File: rtl/text_console_writer_bus_writer.sv
// Single-word request holder: captures one address/data/mask on load, keeps
// wen high until the target accepts, and can be reloaded on the accepting
// edge so consecutive words go out back-to-back.
module console_bus_writer #(
    parameter logic [31:0] BASE_ADDR = 32'h8000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data,
    input  logic [3:0]  load_mask,
    output logic        pending,
    output logic        done,
    text_console_writer_if.master bus
);

    assign done    = bus.wen & bus.ready;
    assign pending = bus.wen;
    assign bus.ren = 1'b0;

    // Request register: load wins over completion so words can chain without a gap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.addr  <= BASE_ADDR;
            bus.wdata <= 32'd0;
            bus.wmask <= 4'd0;
            bus.wen   <= 1'b0;
        end else if (load) begin
            bus.addr  <= load_addr;
            bus.wdata <= load_data;
            bus.wmask <= load_mask;
            bus.wen   <= 1'b1;
        end else if (done) begin
            bus.wen   <= 1'b0;
        end
    end

endmodule

// File: rtl/text_console_writer.sv
// Byte-stream to screenbuffer console. Keeps a cursor, interprets CR/LF/BS/
// TAB/FF, prints everything else raw, and clears rows as the cursor moves onto
// them. The cursor/FSM lives here; bus timing lives in console_bus_writer.
module text_console_writer
    import text_console_writer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = 32'h8000,
    parameter int          COLS           = DEFAULT_COLS,
    parameter int          ROWS           = DEFAULT_ROWS,
    parameter logic [7:0]  FILL_CHAR      = 8'h20,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    text_console_writer_if.master bus,
    output logic [6:0] cursor_col,
    output logic [4:0] cursor_row,
    output logic       busy
);

    localparam int WPR       = COLS / 4;
    localparam int ALL_WORDS = ROWS * WPR;

    state_t      state, state_n;
    logic [6:0]  col_n;
    logic [4:0]  row_n;
    logic [9:0]  wcnt, wcnt_n, wsel;
    logic [7:0]  put_ch, put_ch_n;
    logic        erase, erase_n;
    logic        load, pending, done;
    logic [31:0] load_addr, load_data;
    logic [3:0]  load_mask;
    logic [31:0] cell_idx, word_idx;
    logic [7:0]  tab_col;

    assign busy = (state != ST_IDLE);

    console_bus_writer #(.BASE_ADDR(BASE_ADDR)) u_writer (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .load_addr (load_addr),
        .load_data (load_data),
        .load_mask (load_mask),
        .pending   (pending),
        .done      (done),
        .bus       (bus)
    );

    // State, cursor and word counter registers; in_ready mirrors the next IDLE state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= CLEAR_ON_RESET ? ST_CLR_ALL : ST_IDLE;
            in_ready   <= !CLEAR_ON_RESET;
            cursor_col <= 7'd0;
            cursor_row <= 5'd0;
            wcnt       <= 10'd0;
            put_ch     <= 8'd0;
            erase      <= 1'b0;
        end else begin
            state      <= state_n;
            in_ready   <= (state_n == ST_IDLE);
            cursor_col <= col_n;
            cursor_row <= row_n;
            wcnt       <= wcnt_n;
            put_ch     <= put_ch_n;
            erase      <= erase_n;
        end
    end

    // Byte decode, cursor math and choice of the next bus word.
    // A character write targets the cursor cell; the cursor moves when that write is accepted.
    always_comb begin
        state_n   = state;
        col_n     = cursor_col;
        row_n     = cursor_row;
        wcnt_n    = wcnt;
        put_ch_n  = put_ch;
        erase_n   = erase;
        load      = 1'b0;
        load_addr = BASE_ADDR;
        load_data = {4{FILL_CHAR}};
        load_mask = 4'hF;
        wsel      = done ? (wcnt + 10'd1) : wcnt;
        cell_idx  = 32'(cursor_row) * 32'(COLS) + 32'(cursor_col);
        tab_col   = ({1'b0, cursor_col} | 8'd7) + 8'd1;
        word_idx  = 32'(wsel);

        case (state)
            ST_IDLE: begin
                if (in_valid && in_ready) begin
                    case (in_data)
                        CH_CR: col_n = 7'd0;
                        CH_FF: begin
                            col_n   = 7'd0;
                            row_n   = 5'd0;
                            wcnt_n  = 10'd0;
                            state_n = ST_CLR_ALL;
                        end
                        CH_LF: begin
                            col_n   = 7'd0;
                            row_n   = next_row(cursor_row, ROWS);
                            wcnt_n  = 10'd0;
                            state_n = ST_CLR_LINE;
                        end
                        CH_BS: begin
                            if (cursor_col != 7'd0) begin
                                put_ch_n = FILL_CHAR;
                                erase_n  = 1'b1;
                                state_n  = ST_PUT;
                            end
                        end
                        CH_TAB: begin
                            if (int'(tab_col) >= COLS) begin
                                col_n   = 7'd0;
                                row_n   = next_row(cursor_row, ROWS);
                                wcnt_n  = 10'd0;
                                state_n = ST_CLR_LINE;
                            end else begin
                                col_n = tab_col[6:0];
                            end
                        end
                        default: begin
                            put_ch_n = in_data;
                            erase_n  = 1'b0;
                            state_n  = ST_PUT;
                        end
                    endcase
                end
            end
            ST_PUT: begin
                load_addr = BASE_ADDR + (cell_idx & ~32'd3);
                load_mask = 4'b0001 << cell_idx[1:0];
                load_data = {4{put_ch}};
                load      = !pending;
                if (done) begin
                    if (erase) begin
                        col_n   = cursor_col - 7'd1;
                        state_n = ST_IDLE;
                    end else if (int'(cursor_col) == COLS - 1) begin
                        col_n   = 7'd0;
                        row_n   = next_row(cursor_row, ROWS);
                        wcnt_n  = 10'd0;
                        state_n = ST_CLR_LINE;
                    end else begin
                        col_n   = cursor_col + 7'd1;
                        state_n = ST_IDLE;
                    end
                end
            end
            ST_CLR_LINE: begin
                word_idx  = 32'(cursor_row) * 32'(WPR) + 32'(wsel);
                load_addr = BASE_ADDR + (word_idx << 2);
                load      = !pending || (done && wcnt != 10'(WPR - 1));
                if (done) begin
                    if (wcnt == 10'(WPR - 1)) begin
                        wcnt_n  = 10'd0;
                        state_n = ST_IDLE;
                    end else begin
                        wcnt_n = wcnt + 10'd1;
                    end
                end
            end
            ST_CLR_ALL: begin
                load_addr = BASE_ADDR + (word_idx << 2);
                load      = !pending || (done && wcnt != 10'(ALL_WORDS - 1));
                if (done) begin
                    if (wcnt == 10'(ALL_WORDS - 1)) begin
                        wcnt_n  = 10'd0;
                        state_n = ST_IDLE;
                    end else begin
                        wcnt_n = wcnt + 10'd1;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_text_console_writer.sv
// Self-checking bench for text_console_writer: a screen-level model turns each
// accepted byte into the list of bus words it must cause, and a monitor
// compares every accepted write, the cursor whenever idle, and bus stability.
module tb_text_console_writer;

    localparam int          COLS = 80;
    localparam int          ROWS = 30;
    localparam logic [31:0] BASE = 32'h8000;
    localparam logic [7:0]  FILL = 8'h20;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
    } wr_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] in_data = 8'd0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [6:0] cursor_col;
    logic [4:0] cursor_row;
    logic       busy;

    int  checks = 0;
    int  failures = 0;
    wr_t exp_q[$];
    wr_t model_out[$];
    int  mcol = 0;
    int  mrow = 0;
    bit  rand_ready = 1'b0;
    bit  stall = 1'b0;

    logic        prev_hold = 1'b0;
    logic [31:0] prev_addr, prev_wdata;
    logic [3:0]  prev_wmask;

    text_console_writer_if bus();

    text_console_writer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .bus        (bus),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Screen model: cell index -> word address and byte lane.
    function automatic void push_cell(input int r, input int c, input logic [7:0] ch);
        int  i;
        wr_t w;
        i = r * COLS + c;
        w.addr = BASE + 32'(4 * (i / 4));
        w.data = {4{ch}};
        w.mask = 4'(1 << (i % 4));
        model_out.push_back(w);
    endfunction

    function automatic void push_row_clear(input int r);
        wr_t w;
        for (int k = 0; k < COLS / 4; k++) begin
            w.addr = BASE + 32'(4 * (r * (COLS / 4) + k));
            w.data = {4{FILL}};
            w.mask = 4'hF;
            model_out.push_back(w);
        end
    endfunction

    function automatic void push_screen_clear();
        for (int r = 0; r < ROWS; r++) push_row_clear(r);
    endfunction

    function automatic void line_feed(inout int c, inout int r);
        c = 0;
        r = (r + 1) % ROWS;
        push_row_clear(r);
    endfunction

    function automatic void model_byte(input logic [7:0] b, inout int c, inout int r);
        int nc;
        case (b)
            8'h0D: c = 0;
            8'h0C: begin c = 0; r = 0; push_screen_clear(); end
            8'h0A: line_feed(c, r);
            8'h08: if (c > 0) begin push_cell(r, c, FILL); c = c - 1; end
            8'h09: begin
                nc = (c | 7) + 1;
                if (nc >= COLS) line_feed(c, r);
                else c = nc;
            end
            default: begin
                push_cell(r, c, b);
                if (c == COLS - 1) line_feed(c, r);
                else c = c + 1;
            end
        endcase
    endfunction

    task automatic drain_model();
        while (model_out.size() > 0) exp_q.push_back(model_out.pop_front());
    endtask

    task automatic model_reset();
        exp_q.delete();
        model_out.delete();
        mcol = 0;
        mrow = 0;
        push_screen_clear();
        drain_model();
    endtask

    // Target ready: constant high, randomly throttled, or held low for a stall.
    initial begin
        bus.ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (stall) bus.ready = 1'b0;
            else if (rand_ready) bus.ready = ($urandom_range(0, 3) != 0);
            else bus.ready = 1'b1;
        end
    end

    // Compare process: sampled on the falling edge, mid-cycle.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_hold = 1'b0;
            end else begin
                checkOutput("ren", 32'(bus.ren), 32'd0);
                checkOutput("in_ready_vs_busy", 32'(in_ready), 32'(!busy));
                if (prev_hold) begin
                    checkOutput("hold_wen", 32'(bus.wen), 32'd1);
                    checkOutput("hold_addr", bus.addr, prev_addr);
                    checkOutput("hold_wdata", bus.wdata, prev_wdata);
                    checkOutput("hold_wmask", 32'(bus.wmask), 32'(prev_wmask));
                end
                if (!busy && in_ready) begin
                    checkOutput("idle_cursor_col", 32'(cursor_col), 32'(mcol));
                    checkOutput("idle_cursor_row", 32'(cursor_row), 32'(mrow));
                    checkOutput("idle_no_pending_writes", 32'(exp_q.size()), 32'd0);
                end
                if (bus.wen && bus.ready) begin
                    if (exp_q.size() == 0) begin
                        checkOutput("unexpected_write_addr", bus.addr, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("write_addr", bus.addr, e.addr);
                        checkOutput("write_data", bus.wdata, e.data);
                        checkOutput("write_mask", 32'(bus.wmask), 32'(e.mask));
                    end
                end
                if (in_valid && in_ready) begin
                    model_byte(in_data, mcol, mrow);
                    drain_model();
                end
                prev_hold  = bus.wen && !bus.ready;
                prev_addr  = bus.addr;
                prev_wdata = bus.wdata;
                prev_wmask = bus.wmask;
            end
        end
    end

    task automatic applyStimulus(input logic [7:0] b);
        bit got;
        got = 1'b0;
        @(posedge clk);
        #1;
        in_data  = b;
        in_valid = 1'b1;
        for (int n = 0; n < 5000 && !got; n++) begin
            @(negedge clk);
            if (in_ready) got = 1'b1;
        end
        if (!got) checkOutput("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < budget && !ok; n++) begin
            @(negedge clk);
            if (!busy && in_ready && !in_valid) ok = 1'b1;
        end
        if (!ok) checkOutput("idle_timeout", 32'd0, 32'd1);
    endtask

    // Pins on the model itself, from hand-computed screen arithmetic.
    task automatic pin_model();
        int c, r;
        model_out.delete();
        push_screen_clear();
        checkOutput("pin_clear_count", 32'(model_out.size()), 32'd600);
        checkOutput("pin_clear_last_addr", model_out[599].addr, 32'h895C);
        checkOutput("pin_clear_data", model_out[0].data, 32'h2020_2020);
        model_out.delete();
        c = 0; r = 0;
        model_byte(8'h41, c, r);
        checkOutput("pin_A_addr", model_out[0].addr, 32'h8000);
        checkOutput("pin_A_mask", 32'(model_out[0].mask), 32'h1);
        checkOutput("pin_A_data", model_out[0].data, 32'h4141_4141);
        model_byte(8'h42, c, r);
        checkOutput("pin_B_mask", 32'(model_out[1].mask), 32'h2);
        checkOutput("pin_B_col", 32'(c), 32'd2);
        model_out.delete();
        c = 5; r = 2;
        model_byte(8'h08, c, r);
        checkOutput("pin_bs_addr", model_out[0].addr, 32'h80A4);
        checkOutput("pin_bs_mask", 32'(model_out[0].mask), 32'h2);
        checkOutput("pin_bs_col", 32'(c), 32'd4);
        model_out.delete();
        c = 0;
        model_byte(8'h08, c, r);
        checkOutput("pin_bs_col0_nowrite", 32'(model_out.size()), 32'd0);
        c = 0; r = 29;
        model_byte(8'h0A, c, r);
        checkOutput("pin_lf_wrap_row", 32'(r), 32'd0);
        checkOutput("pin_lf_first", model_out[0].addr, 32'h8000);
        checkOutput("pin_lf_last", model_out[19].addr, 32'h804C);
        model_out.delete();
        c = 79; r = 0;
        model_byte(8'h41, c, r);
        checkOutput("pin_eol_addr", model_out[0].addr, 32'h804C);
        checkOutput("pin_eol_mask", 32'(model_out[0].mask), 32'h8);
        checkOutput("pin_eol_clear0", model_out[1].addr, 32'h8050);
        checkOutput("pin_eol_clear19", model_out[20].addr, 32'h809C);
        model_out.delete();
        c = 3; r = 0;
        model_byte(8'h09, c, r);
        checkOutput("pin_tab_col", 32'(c), 32'd8);
        c = 75;
        model_byte(8'h09, c, r);
        checkOutput("pin_tab_wrap_row", 32'(r), 32'd1);
        model_out.delete();
    endtask

    initial begin
        logic [7:0] b;
        int         sel;
        bit         seen;
        pin_model();
        model_reset();
        #23 rst_n = 1'b1;

        wait_idle(3000);
        checkOutput("reset_cursor_col", 32'(cursor_col), 32'd0);
        checkOutput("reset_cursor_row", 32'(cursor_row), 32'd0);
        checkOutput("reset_in_ready", 32'(in_ready), 32'd1);

        applyStimulus(8'h41);
        applyStimulus(8'h42);
        wait_idle(200);
        checkOutput("ab_col", 32'(cursor_col), 32'd2);

        applyStimulus(8'h0D);
        for (int i = 0; i < COLS; i++) applyStimulus(8'h41);
        wait_idle(500);
        checkOutput("fullrow_col", 32'(cursor_col), 32'd0);
        checkOutput("fullrow_row", 32'(cursor_row), 32'd1);

        for (int i = 0; i < 28; i++) applyStimulus(8'h0A);
        wait_idle(500);
        checkOutput("row29", 32'(cursor_row), 32'd29);
        applyStimulus(8'h0A);
        wait_idle(500);
        checkOutput("lf_wrap_row", 32'(cursor_row), 32'd0);

        applyStimulus(8'h0A);
        applyStimulus(8'h0A);
        for (int i = 0; i < 5; i++) applyStimulus(8'h78);
        applyStimulus(8'h08);
        wait_idle(200);
        checkOutput("bs_col", 32'(cursor_col), 32'd4);
        checkOutput("bs_row", 32'(cursor_row), 32'd2);
        applyStimulus(8'h0D);
        applyStimulus(8'h08);
        wait_idle(200);
        checkOutput("bs_col0", 32'(cursor_col), 32'd0);

        rand_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            sel = $urandom_range(0, 99);
            if (sel < 1) b = 8'h0C;
            else if (sel < 8) b = 8'h0A;
            else if (sel < 13) b = 8'h0D;
            else if (sel < 20) b = 8'h08;
            else if (sel < 28) b = 8'h09;
            else b = 8'($urandom_range(0, 255));
            applyStimulus(b);
        end
        wait_idle(5000);

        rand_ready = 1'b0;
        applyStimulus(8'h0C);
        repeat (40) @(posedge clk);
        stall = 1'b1;
        repeat (11) @(posedge clk);
        stall = 1'b0;
        repeat (20) @(posedge clk);

        seen = 1'b0;
        for (int n = 0; n < 200 && !seen; n++) begin
            @(negedge clk);
            if (bus.wen) seen = 1'b1;
        end
        checkOutput("wen_before_reset", 32'(seen), 32'd1);
        #1 rst_n = 1'b0;
        model_reset();
        #1 checkOutput("wen_async_reset", 32'(bus.wen), 32'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        wait_idle(3000);
        checkOutput("rereset_cursor_col", 32'(cursor_col), 32'd0);
        checkOutput("rereset_cursor_row", 32'(cursor_row), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
